// File: rtl/c1541_gcr_deframer_if.sv
// Bit-source and track-buffer side signals of the GCR deframer.
interface c1541_gcr_deframer_if;
    logic       bit_en;
    logic       bit_in;
    logic       mtr;
    logic [5:0] track;
    logic       sync;
    logic [4:0] sector;
    logic [7:0] byte_addr;
    logic [7:0] ram_di;
    logic       ram_we;
    logic       hdr_ok;
    logic       data_ok;
    logic       cks_err;
    logic       gcr_err;

    modport master (
        output bit_en, bit_in, mtr, track,
        input  sync, sector, byte_addr, ram_di, ram_we,
        input  hdr_ok, data_ok, cks_err, gcr_err
    );

    modport slave (
        input  bit_en, bit_in, mtr, track,
        output sync, sector, byte_addr, ram_di, ram_we,
        output hdr_ok, data_ok, cks_err, gcr_err
    );
endinterface

// File: rtl/c1541_gcr_deframer.sv
// 1541 GCR deframer: finds SYNC, frames 10-bit groups into bytes, parses
// header/data blocks and writes decoded sector bytes into the track buffer.
module c1541_gcr_deframer #(
    parameter int unsigned SYNC_BITS = 10
) (
    input  logic                  clk32,
    input  logic                  reset_n,
    c1541_gcr_deframer_if.slave   bus
);

    localparam int unsigned ONES_W     = 5;
    localparam int unsigned ONES_MAX   = 31;
    localparam int unsigned BIT_W      = 4;
    localparam int unsigned IDX_W      = 9;
    localparam int unsigned HDR_LAST   = 5;
    localparam int unsigned DATA_BYTES = 256;
    localparam int unsigned MAX_SECTOR = 20;
    localparam logic [7:0]  MARK_HDR   = 8'h08;
    localparam logic [7:0]  MARK_DATA  = 8'h07;

    typedef enum logic [2:0] {
        S_HUNT,
        S_SYNC,
        S_MARK,
        S_HEADER,
        S_DATA
    } state_e;

    // Inverse GCR table: {valid, nibble}
    function automatic logic [4:0] gcr_dec(input logic [4:0] code);
        case (code)
            5'b01010: gcr_dec = 5'h10;
            5'b01011: gcr_dec = 5'h11;
            5'b10010: gcr_dec = 5'h12;
            5'b10011: gcr_dec = 5'h13;
            5'b01110: gcr_dec = 5'h14;
            5'b01111: gcr_dec = 5'h15;
            5'b10110: gcr_dec = 5'h16;
            5'b10111: gcr_dec = 5'h17;
            5'b01001: gcr_dec = 5'h18;
            5'b11001: gcr_dec = 5'h19;
            5'b11010: gcr_dec = 5'h1A;
            5'b11011: gcr_dec = 5'h1B;
            5'b01101: gcr_dec = 5'h1C;
            5'b11101: gcr_dec = 5'h1D;
            5'b11110: gcr_dec = 5'h1E;
            5'b10101: gcr_dec = 5'h1F;
            default:  gcr_dec = 5'h00;
        endcase
    endfunction

    state_e             state_q, state_d;
    logic [ONES_W-1:0]  ones_q, ones_d;
    logic               sync_q, sync_d;
    logic [8:0]         shift_q, shift_d;
    logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         xor_q, xor_d;
    logic               hdr_valid_q, hdr_valid_d;
    logic [5:0]         track_q, track_d;
    logic [4:0]         sector_q, sector_d;
    logic [7:0]         h_cks_q, h_cks_d;
    logic [7:0]         h_sec_q, h_sec_d;
    logic [7:0]         h_trk_q, h_trk_d;
    logic [7:0]         h_id2_q, h_id2_d;
    logic [7:0]         byte_addr_q, byte_addr_d;
    logic [7:0]         ram_di_q, ram_di_d;
    logic               ram_we_q, ram_we_d;
    logic               hdr_ok_q, hdr_ok_d;
    logic               data_ok_q, data_ok_d;
    logic               cks_err_q, cks_err_d;
    logic               gcr_err_q, gcr_err_d;

    logic [ONES_W-1:0]  ones_inc;
    logic               sync_hit;
    logic [9:0]         word;
    logic [4:0]         dec_hi;
    logic [4:0]         dec_lo;
    logic [7:0]         byte_val;
    logic               code_ok;
    logic               hdr_good;

    assign ones_inc = (ones_q == ONES_W'(ONES_MAX)) ? ones_q : ones_q + ONES_W'(1);
    assign sync_hit = bus.bit_en && bus.bit_in && (ones_inc >= ONES_W'(SYNC_BITS));
    assign word     = {shift_q, bus.bit_in};
    assign dec_hi   = gcr_dec(word[9:5]);
    assign dec_lo   = gcr_dec(word[4:0]);
    assign byte_val = {dec_hi[3:0], dec_lo[3:0]};
    assign code_ok  = dec_hi[4] && dec_lo[4];
    // byte_val is id1 when the header is evaluated
    assign hdr_good = (h_cks_q == (h_sec_q ^ h_trk_q ^ h_id2_q ^ byte_val))
                   && (h_trk_q == 8'(bus.track))
                   && (h_sec_q <= 8'(MAX_SECTOR));

    always_comb begin
        state_d     = state_q;
        ones_d      = ones_q;
        sync_d      = sync_q;
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        idx_d       = idx_q;
        xor_d       = xor_q;
        hdr_valid_d = hdr_valid_q;
        track_d     = bus.track;
        sector_d    = sector_q;
        h_cks_d     = h_cks_q;
        h_sec_d     = h_sec_q;
        h_trk_d     = h_trk_q;
        h_id2_d     = h_id2_q;
        byte_addr_d = byte_addr_q;
        ram_di_d    = ram_di_q;
        ram_we_d    = 1'b0;
        hdr_ok_d    = 1'b0;
        data_ok_d   = 1'b0;
        cks_err_d   = 1'b0;
        gcr_err_d   = 1'b0;

        if (bus.track != track_q) begin
            hdr_valid_d = 1'b0;
            sector_d    = 5'd0;
        end

        if (!bus.mtr) begin
            state_d     = S_HUNT;
            hdr_valid_d = 1'b0;
            ones_d      = '0;
            sync_d      = 1'b0;
        end else if (bus.bit_en) begin
            ones_d  = bus.bit_in ? ones_inc : '0;
            sync_d  = sync_hit;
            shift_d = word[8:0];
            // SYNC wins over a byte completing on the same bit
            if (sync_hit) begin
                state_d = S_SYNC;
            end else begin
                case (state_q)
                    S_SYNC: begin
                        if (!bus.bit_in) begin
                            state_d  = S_MARK;
                            bitcnt_d = BIT_W'(1);
                        end
                    end
                    S_MARK, S_HEADER, S_DATA: begin
                        if (bitcnt_q != BIT_W'(9)) begin
                            bitcnt_d = bitcnt_q + BIT_W'(1);
                        end else begin
                            bitcnt_d = '0;
                            idx_d    = idx_q + IDX_W'(1);
                            if (!code_ok) begin
                                gcr_err_d = 1'b1;
                                state_d   = S_HUNT;
                            end else if (state_q == S_MARK) begin
                                idx_d = IDX_W'(1);
                                xor_d = 8'h00;
                                if (byte_val == MARK_HDR)
                                    state_d = S_HEADER;
                                else if (byte_val == MARK_DATA && hdr_valid_q)
                                    state_d = S_DATA;
                                else
                                    state_d = S_HUNT;
                            end else if (state_q == S_HEADER) begin
                                case (idx_q)
                                    IDX_W'(1): h_cks_d = byte_val;
                                    IDX_W'(2): h_sec_d = byte_val;
                                    IDX_W'(3): h_trk_d = byte_val;
                                    IDX_W'(4): h_id2_d = byte_val;
                                    default:   ;
                                endcase
                                if (idx_q == IDX_W'(HDR_LAST)) begin
                                    state_d = S_HUNT;
                                    if (hdr_good) begin
                                        sector_d    = h_sec_q[4:0];
                                        hdr_valid_d = 1'b1;
                                        hdr_ok_d    = 1'b1;
                                    end else begin
                                        hdr_valid_d = 1'b0;
                                        cks_err_d   = 1'b1;
                                    end
                                end
                            end else begin
                                if (idx_q <= IDX_W'(DATA_BYTES)) begin
                                    ram_we_d    = 1'b1;
                                    ram_di_d    = byte_val;
                                    byte_addr_d = 8'(idx_q - IDX_W'(1));
                                    xor_d       = xor_q ^ byte_val;
                                end else begin
                                    data_ok_d   = (byte_val == xor_q);
                                    cks_err_d   = (byte_val != xor_q);
                                    hdr_valid_d = 1'b0;
                                    state_d     = S_HUNT;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_HUNT;
            ones_q      <= '0;
            sync_q      <= 1'b0;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            idx_q       <= '0;
            xor_q       <= '0;
            hdr_valid_q <= 1'b0;
            track_q     <= '0;
            sector_q    <= '0;
            h_cks_q     <= '0;
            h_sec_q     <= '0;
            h_trk_q     <= '0;
            h_id2_q     <= '0;
            byte_addr_q <= '0;
            ram_di_q    <= '0;
            ram_we_q    <= 1'b0;
            hdr_ok_q    <= 1'b0;
            data_ok_q   <= 1'b0;
            cks_err_q   <= 1'b0;
            gcr_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ones_q      <= ones_d;
            sync_q      <= sync_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            idx_q       <= idx_d;
            xor_q       <= xor_d;
            hdr_valid_q <= hdr_valid_d;
            track_q     <= track_d;
            sector_q    <= sector_d;
            h_cks_q     <= h_cks_d;
            h_sec_q     <= h_sec_d;
            h_trk_q     <= h_trk_d;
            h_id2_q     <= h_id2_d;
            byte_addr_q <= byte_addr_d;
            ram_di_q    <= ram_di_d;
            ram_we_q    <= ram_we_d;
            hdr_ok_q    <= hdr_ok_d;
            data_ok_q   <= data_ok_d;
            cks_err_q   <= cks_err_d;
            gcr_err_q   <= gcr_err_d;
        end
    end

    assign bus.sync      = sync_q;
    assign bus.sector    = sector_q;
    assign bus.byte_addr = byte_addr_q;
    assign bus.ram_di    = ram_di_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.hdr_ok    = hdr_ok_q;
    assign bus.data_ok   = data_ok_q;
    assign bus.cks_err   = cks_err_q;
    assign bus.gcr_err   = gcr_err_q;

endmodule
